// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv_fetch_pkg;

  // Canonical NOP (addi x0, x0, 0), used as the payload of a misaligned-target entry
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One prefetched instruction as handed to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t with push, pop and flush.
// A flush empties the queue; a push in the same cycle lands as the sole entry.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_pop;
  logic [AW-1:0]   wr_addr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign wr_addr = flush_i ? '0 : wr_ptr_q;

  // Storage array: written on push, no reset needed
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_addr] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush restarts both pointers at slot 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push_i ? AW'(1) : '0;
      count_q  <= push_i ? CW'(1) : '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, memory request credits, response
// drop counter for redirects, and a prefetch FIFO feeding decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned targets produce a
// single flagged NOP entry and halt fetch until the next redirect/trap).
module if_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misaligned
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;     // PC of the next response that will be kept
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          halted;

  logic          redir;
  logic [31:0]   target_raw, target;
  logic          target_mis;
  logic          pop;
  logic          req_fire;
  logic [CW:0]   credits_used;
  logic          fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry, head;

  // Redirect mux: trap entry/return outranks a branch in the same cycle
  assign redir      = trap_valid || redirect_valid;
  assign target_raw = trap_valid ? trap_pc : redirect_pc;
  assign target_mis = MISALIGN_EN && (target_raw[1:0] != 2'b00);
  assign target     = MISALIGN_EN ? target_raw : {target_raw[31:2], 2'b00};

  // A same-cycle pop frees a slot before any new response can land, so it
  // counts as a returned credit; this keeps one request per cycle flowing.
  assign pop          = out_valid && out_ready;
  assign credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

  assign imem_req_valid = rst && !halted && !redir && (credits_used < (CW+1)'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are kept only when nothing is owed to the drop counter and no
  // redirect is flushing the queue; a misaligned target injects its own entry.
  always_comb begin
    fifo_push  = 1'b0;
    push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data, misaligned: 1'b0};
    if (redir) begin
      fifo_push  = target_mis;
      push_entry = '{pc: target, inst: NOP_INST, misaligned: 1'b1};
    end else if (imem_rsp_valid && (drop_cnt_q == '0)) begin
      fifo_push = 1'b1;
    end
  end

  // Next-state for PC, response PC, outstanding and drop counters
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redir) begin
      pc_d       = target;
      rsp_pc_d   = target;
      // Everything still in flight after this cycle belongs to the old stream
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q;

  // Halt after a misaligned target; only a fresh redirect/trap resumes fetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (redir) begin
      halted_q <= target_mis;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redir),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid      = !fifo_empty;
  assign out_pc         = head.pc;
  assign out_inst       = head.inst;
  assign out_misaligned = MISALIGN_EN && head.misaligned;

  // The credit rule must never let a response find the queue full
  assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full && !redir));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: in-order memory model with random latency and a
// stream-level reference (expected request PC / expected delivered PC).
module tb_if_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid, trap_valid;
  logic [31:0] redirect_pc, trap_pc;
  logic        out_valid, out_ready, out_misaligned;
  logic [31:0] out_pc, out_inst;

  if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_misaligned(out_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus controls
  bit          req_ready_rand, oready_rand, oready_val;
  int          lat_min, lat_max;
  bit          do_redir, do_trap;
  logic [31:0] redir_tgt, trap_tgt;

  // reference model
  logic [31:0] exp_req_pc, exp_out_pc;
  bit          model_halt, exp_mis;
  int          cyc, req_fires;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] pop_pcs[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive inputs, score what fires at the coming edge, advance.
  task automatic step();
    bit          redir, flush_exp;
    logic [31:0] tgt;
    imem_req_ready = req_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready      = oready_rand ? ($urandom_range(0, 3) != 0) : oready_val;
    imem_rsp_valid = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mq_addr[0]) : $urandom;
    redirect_valid = do_redir; redirect_pc = redir_tgt;
    trap_valid     = do_trap;  trap_pc     = trap_tgt;
    #1;
    redir = do_redir || do_trap;
    tgt   = do_trap ? trap_tgt : redir_tgt;
    flush_exp = 1'b0;

    n_checks++;
    if (imem_req_valid && (redir || model_halt)) begin
      n_fail++; $display("FAIL req_blocked: imem_req_valid=%0b required 0 (cyc %0d)", imem_req_valid, cyc);
    end
    if (mq_addr.size() > 0 && imem_rsp_valid) begin
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      n_checks++;
      if (imem_addr !== exp_req_pc) begin
        n_fail++; $display("FAIL req_addr: got %h required %h (cyc %0d)", imem_addr, exp_req_pc, cyc);
      end
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + $urandom_range(lat_min, lat_max));
      exp_req_pc = imem_addr + 32'd4;
      req_fires++;
    end
    n_checks++;
    if (mq_addr.size() > DEPTH) begin
      n_fail++; $display("FAIL credits: %0d requests in flight, limit %0d", mq_addr.size(), DEPTH);
    end
    if (out_valid && out_ready) begin
      n_checks++;
      if (out_pc !== exp_out_pc) begin
        n_fail++; $display("FAIL out_pc: got %h required %h (cyc %0d)", out_pc, exp_out_pc, cyc);
      end
      n_checks++;
      if (exp_mis) begin
        if (out_inst !== NOP || out_misaligned !== 1'b1) begin
          n_fail++; $display("FAIL mis_entry: inst %h mis %0b required %h 1", out_inst, out_misaligned, NOP);
        end
        exp_mis = 1'b0;
      end else if (out_inst !== mem_word(out_pc) || out_misaligned !== 1'b0) begin
        n_fail++; $display("FAIL out_inst: inst %h mis %0b required %h 0", out_inst, out_misaligned, mem_word(out_pc));
      end
      pop_pcs.push_back(out_pc);
      pop_cyc.push_back(cyc);
      exp_out_pc = out_pc + 32'd4;
    end
    if (redir) begin
      model_halt = 1'b0;
      exp_mis    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        model_halt = 1'b1; exp_mis = 1'b1; flush_exp = 1'b1;
        exp_out_pc = tgt; exp_req_pc = tgt;
      end else begin
        exp_out_pc = tgt; exp_req_pc = tgt;
      end
`else
      exp_out_pc = {tgt[31:2], 2'b00};
      exp_req_pc = {tgt[31:2], 2'b00};
`endif
    end
    do_redir = 1'b0; do_trap = 1'b0;
    @(negedge clk);
    cyc++;
    if (redir) begin
      n_checks++;
      if (out_valid !== flush_exp) begin
        n_fail++; $display("FAIL flush: out_valid=%0b required %0b after redirect", out_valid, flush_exp);
      end
    end
  endtask

  task automatic wait_pops(input int n);
    int budget = 40;
    while (pop_pcs.size() < n && budget > 0) begin step(); budget--; end
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; trap_valid = 1'b0; redirect_pc = '0; trap_pc = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset: req_valid %0b out_valid %0b addr %h required 0 0 %h",
                         imem_req_valid, out_valid, imem_addr, RESET_PC);
    end
    rst = 1'b1;
    exp_req_pc = RESET_PC; exp_out_pc = RESET_PC; cyc = 0; req_fires = 0;
  endtask

  task automatic test_stream();
    req_ready_rand = 0; oready_rand = 0; oready_val = 1; lat_min = 1; lat_max = 1;
    pop_pcs.delete(); pop_cyc.delete();
    repeat (6) step();
    n_checks++;
    if (pop_pcs.size() < 3) begin
      n_fail++; $display("FAIL stream_count: got %0d pops required >=3", pop_pcs.size());
    end else begin
      if (pop_pcs[0] !== 32'h0 || pop_pcs[1] !== 32'h4 || pop_pcs[2] !== 32'h8) begin
        n_fail++; $display("FAIL stream_pc: got %h %h %h required 0 4 8", pop_pcs[0], pop_pcs[1], pop_pcs[2]);
      end
      n_checks++;
      if (pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[1] + 1) begin
        n_fail++; $display("FAIL stream_rate: pops at %0d %0d %0d required consecutive", pop_cyc[0], pop_cyc[1], pop_cyc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          f0;
    logic [31:0] first;
    oready_val = 0;
    repeat (5) step();
    f0 = req_fires;
    repeat (5) step();
    n_checks++;
    if (req_fires != f0 || ((exp_req_pc - exp_out_pc) >> 2) != DEPTH) begin
      n_fail++; $display("FAIL stall: %0d late requests, %0d undelivered required 0 and %0d",
                         req_fires - f0, (exp_req_pc - exp_out_pc) >> 2, DEPTH);
    end
    first = exp_out_pc;
    oready_val = 1; pop_pcs.delete(); pop_cyc.delete();
    repeat (10) step();
    n_checks++;
    if (pop_pcs.size() < DEPTH || pop_pcs[0] !== first) begin
      n_fail++; $display("FAIL resume: %0d pops first %h required >=%0d first %h",
                         pop_pcs.size(), (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hx, DEPTH, first);
    end
  endtask

  task automatic test_redirect_inflight();
    int budget = 20;
    lat_min = 3; lat_max = 3;
    while (mq_addr.size() != 2 && budget > 0) begin step(); budget--; end
    n_checks++;
    if (mq_addr.size() != 2) begin
      n_fail++; $display("FAIL inflight_setup: %0d in flight required 2", mq_addr.size());
    end
    do_redir = 1; redir_tgt = 32'h100;
    step();
    lat_min = 1; lat_max = 1; pop_pcs.delete();
    wait_pops(2);
    n_checks++;
    if (pop_pcs.size() < 2 || pop_pcs[0] !== 32'h100 || pop_pcs[1] !== 32'h104) begin
      n_fail++; $display("FAIL redirect_drop: %0d pops required 2 starting 00000100 00000104", pop_pcs.size());
    end
  endtask

  task automatic test_trap_priority();
    do_trap = 1; trap_tgt = 32'h200; do_redir = 1; redir_tgt = 32'h100;
    step();
    pop_pcs.delete();
    wait_pops(1);
    n_checks++;
    if (pop_pcs.size() < 1 || pop_pcs[0] !== 32'h200) begin
      n_fail++; $display("FAIL trap_prio: %0d pops required first 00000200", pop_pcs.size());
    end
  endtask

  task automatic test_wrap();
    do_redir = 1; redir_tgt = 32'hFFFF_FFFC;
    step();
    pop_pcs.delete();
    wait_pops(2);
    n_checks++;
    if (pop_pcs.size() < 2 || pop_pcs[0] !== 32'hFFFF_FFFC || pop_pcs[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap: %0d pops required fffffffc then 00000000", pop_pcs.size());
    end
  endtask

  task automatic test_misalign();
    do_redir = 1; redir_tgt = 32'h102;
    step();
    pop_pcs.delete();
    wait_pops(1);
`ifdef FETCH_MISALIGN_TRAP_EN
    begin
      int f0 = req_fires;
      repeat (8) step();
      n_checks++;
      if (pop_pcs.size() != 1 || pop_pcs[0] !== 32'h102 || req_fires != f0) begin
        n_fail++; $display("FAIL misalign_halt: %0d pops %0d requests required 1 pop at 00000102, 0 requests",
                           pop_pcs.size(), req_fires - f0);
      end
      do_redir = 1; redir_tgt = 32'h300;
      step();
    end
`else
    n_checks++;
    if (pop_pcs.size() < 1 || pop_pcs[0] !== 32'h100) begin
      n_fail++; $display("FAIL misalign_force: %0d pops required first 00000100", pop_pcs.size());
    end
`endif
  endtask

  task automatic test_random();
    int p0;
    req_ready_rand = 1; oready_rand = 1; lat_min = 1; lat_max = 4;
    p0 = pop_pcs.size();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_redir = 1; redir_tgt = $urandom;
        if ($urandom_range(0, 2) == 0) begin do_trap = 1; trap_tgt = $urandom; end
      end
      step();
    end
    n_checks++;
    if (pop_pcs.size() - p0 < 50) begin
      n_fail++; $display("FAIL progress: %0d instructions delivered required >=50", pop_pcs.size() - p0);
    end
  endtask

  initial begin
    do_redir = 0; do_trap = 0; redir_tgt = '0; trap_tgt = '0;
    model_halt = 0; exp_mis = 0;
    req_ready_rand = 0; oready_rand = 0; oready_val = 1; lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_trap_priority();
    test_wrap();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
